// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// UART receiver (8 data bits, LSB first, 1 stop bit) with a small receive
// FIFO and valid/ready handshake on the read side.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   -> 8E1, one even-parity bit after the data bits
//   undefined -> 8N1, parity_err tied low
//
// Ports
//   clk        system clock; all state changes on its rising edge
//   reset_n    asynchronous active-low reset
//   rx         serial line, idle high, asynchronous to clk
//   data       byte at the FIFO head
//   valid      FIFO not empty; data is meaningful
//   ready      consumer takes the head byte when valid && ready
//   frame_err  one-cycle pulse: stop bit sampled low
//   parity_err one-cycle pulse: parity mismatch
//   overrun    one-cycle pulse: received byte dropped because FIFO full
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 115200,
    parameter int DEPTH    = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun
);

    localparam int DIV   = CLK_FREQ / (BAUD * 16);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t           state;
    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    logic [DIV_W-1:0] div_cnt;
    logic [3:0]       os_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;
    logic             par_bad;

    logic             tick;
    logic             sample;
    logic             fall;
    logic             push;
    logic             pop;
    logic             full;
    logic             push_ok;

    logic [7:0]       mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    // Synchronizer is preset to the idle level so reset never looks like a
    // start edge; rx_prev gives the edge detector its previous value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign fall = rx_prev && !rx_sync;
    assign tick = (div_cnt == DIV_W'(DIV - 1));

    // Start bit is checked mid-bit (8th tick); every later bit is sampled
    // 16 ticks after the previous sample, i.e. also mid-bit.
    always_comb begin
        sample = 1'b0;
        if (tick) begin
            if (state == START) sample = (os_cnt == 4'd7);
            else                sample = (os_cnt == 4'd15);
        end
    end

    // A byte is pushed only on a good stop bit with no parity error.
    assign push = (state == STOP) && sample && rx_sync && !par_bad;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            div_cnt   <= '0;
            os_cnt    <= 4'd0;
            bit_cnt   <= 3'd0;
            shift     <= 8'h00;
            par_bad   <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (state == IDLE) begin
                // Holding the divider at zero here is what clears it on
                // entry to START.
                div_cnt <= '0;
                os_cnt  <= 4'd0;
                bit_cnt <= 3'd0;
                par_bad <= 1'b0;
                if (fall) state <= START;
            end else begin
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
                if (tick) begin
                    os_cnt <= sample ? 4'd0 : os_cnt + 4'd1;
                end
                if (sample) begin
                    case (state)
                        START: begin
                            bit_cnt <= 3'd0;
                            state   <= rx_sync ? IDLE : DATA;
                        end
                        DATA: begin
                            shift   <= {rx_sync, shift[7:1]};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end
                        end
`ifdef UART_RX_PARITY_EN
                        PARITY: begin
                            // Even parity: data ones plus parity bit must be even.
                            par_bad <= (^shift) ^ rx_sync;
                            state   <= STOP;
                        end
`endif
                        STOP: begin
`ifdef UART_RX_PARITY_EN
                            parity_err <= par_bad;
`endif
                            frame_err <= !par_bad && !rx_sync;
                            state     <= IDLE;
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    assign valid   = (count != '0);
    assign data    = mem[rd_ptr];
    assign pop     = valid && ready;
    assign full    = (count == CW'(DEPTH));
    // A pop in the same cycle frees a slot, so a push into a full FIFO is
    // still accepted then.
    assign push_ok = push && (!full || pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= shift;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count   <= count + CW'(push_ok) - CW'(pop);
            overrun <= push && full && !pop;
        end
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, line rate in bit/s.
REQ-003 SHALL have parameter DEPTH, default 4, receive FIFO depth in bytes, power of two >= 2.
REQ-004 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port rx  input  1  serial line (board RsRx), idle high, asynchronous to clk.
REQ-007 SHALL have port data  output  8  byte at FIFO head.
REQ-008 SHALL have port valid  output  1  FIFO non-empty, data meaningful.
REQ-009 SHALL have port ready  input  1  consumer accepts head byte when valid&&ready.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-011 SHALL have port parity_err  output  1  one-cycle pulse, parity mismatch.
REQ-012 SHALL have port overrun  output  1  one-cycle pulse, completed byte dropped because FIFO full.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer (preset to 1 in reset) before any use.
REQ-014 SHALL generate an oversample tick every DIV = CLK_FREQ/(BAUD*16) clocks (integer division), counter free-running while not in IDLE, cleared on entering START.
REQ-015 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-016 IDLE -> START SHALL occur on a synchronized high-to-low transition only; a line held low never retriggers.
REQ-017 START SHALL sample at tick 8; low -> DATA, high -> IDLE with no output (glitch rejection).
REQ-018 DATA SHALL sample every 16 ticks thereafter, 8 bits, LSB first.
REQ-019 STOP SHALL sample 16 ticks after the last data (or parity) bit; high -> push byte; low -> frame_err pulse, byte discarded; both -> IDLE.
REQ-020 A pushed byte SHALL appear as valid the clock after the stop-bit sample when the FIFO was empty.
REQ-021 FIFO SHALL pop on valid&&ready; data SHALL hold stable while valid&&!ready.
REQ-022 Push when full SHALL be accepted if a pop occurs in the same cycle; otherwise byte discarded and overrun pulsed; FIFO contents unchanged.
REQ-023 Pointers SHALL wrap modulo DEPTH; full/empty from a (log2(DEPTH)+1)-bit count.
REQ-024 Pop and push in the same cycle on empty FIFO SHALL not occur (valid=0), push proceeds normally.
REQ-025 At most one error pulse SHALL be raised per frame; parity_err takes precedence over frame_err.

Reset
REQ-026 On reset_n low, immediately: FSM=IDLE, FIFO empty, valid=0, data=0x00, frame_err=parity_err=overrun=0, tick and bit counters 0.
REQ-027 Reset mid-frame SHALL discard the partial byte; after release a new falling edge is required to start.

Configuration
REQ-028 With macro UART_RX_PARITY_EN defined, SHALL expect one even-parity bit after data (state PARITY); mismatch -> parity_err pulse, byte discarded, stop bit still consumed.
REQ-029 Without UART_RX_PARITY_EN, SHALL be 8N1, PARITY state unreachable, parity_err tied 0.

Verification (CLK_FREQ=16*BAUD*4, DIV=4, DEPTH=4)
REQ-030 Send 0x55 8N1, ready=1 -> valid one cycle with data=0x55, no error pulses.
REQ-031 Low pulse of 5 oversample ticks on idle line -> no valid, no error, FSM back in IDLE.
REQ-032 Send 0xA3 with stop bit 0 -> frame_err one cycle, valid stays 0.
REQ-033 ready=0, send 0x01..0x05 -> overrun pulse on 5th; then ready=1 -> drains 0x01,0x02,0x03,0x04 in order, then valid=0.
REQ-034 Deassert reset_n during bit 4 of 0x7E, release, send 0x3C -> only 0x3C delivered.
REQ-035 UART_RX_PARITY_EN defined: 0x07 with parity 1 -> 0x07 delivered; with parity 0 -> parity_err pulse, no valid.
